csr_stream_arb_demux: RTL and testbench

Stream fabric block for the accelerator CSR path, used between one Snitch CSR port and `NumAcc` accelerator CSR ports. The request direction uses a combinational select-driven 1-to-N valid/ready demultiplexer. The response direction uses an N-to-1 round-robin data arbiter with grant lock-in. Request payload (addr/data/wen) is broadcast outside this block; only handshakes pass through the demux.

---
 rtl/csr_stream_arb_demux.sv | 157 +++++++++++++++
 tb/tb_csr_stream_arb_demux.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_stream_arb_demux.sv
// csr_stream_arb_demux
// Handshake fabric for the accelerator CSR path:
//   - request side: select-driven 1-to-NumOut valid/ready demultiplexer
//     (stateless, purely combinational; payload is broadcast elsewhere)
//   - response side: NumInp-to-1 round-robin arbiter that locks its grant
//     while the downstream stalls, so a presented beat never changes.
module csr_stream_arb_demux #(
    parameter int unsigned NumOut    = 2,
    parameter int unsigned NumInp    = 2,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned SelWidth  = (NumOut > 1) ? $clog2(NumOut) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // request demux
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [SelWidth-1:0]           req_sel_i,
    output logic [NumOut-1:0]             req_valid_o,
    input  logic [NumOut-1:0]             req_ready_i,
    // response arbiter
    input  logic [NumInp*DataWidth-1:0]   rsp_data_i,
    input  logic [NumInp-1:0]             rsp_valid_i,
    output logic [NumInp-1:0]             rsp_ready_o,
    output logic [DataWidth-1:0]          rsp_data_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i
);

    localparam int unsigned PtrWidth = (NumInp > 1) ? $clog2(NumInp) : 1;

    // ------------------------------------------------------------------
    // Request demux
    // ------------------------------------------------------------------
    // One-hot decode of the select; an out-of-range select hits nothing,
    // which leaves every valid low and the upstream ready low (stall).
    logic [NumOut-1:0] sel_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NumOut; gi++) begin : g_sel_dec
            assign sel_hit[gi] = (req_sel_i == SelWidth'(gi));
        end
    endgenerate

    assign req_valid_o = {NumOut{req_valid_i}} & sel_hit;
    assign req_ready_o = |(req_ready_i & sel_hit);

    // ------------------------------------------------------------------
    // Response arbiter state
    // ------------------------------------------------------------------
    logic [PtrWidth-1:0]  ptr_q, ptr_d;
    logic                 locked_q, locked_d;
    logic [PtrWidth-1:0]  lock_idx_q, lock_idx_d;

    logic                 hi_found, lo_found;
    logic [PtrWidth-1:0]  hi_idx, lo_idx;
    logic [PtrWidth-1:0]  rr_idx;
    logic [PtrWidth-1:0]  grant_idx;
    logic                 sel_valid;
    logic [DataWidth-1:0] sel_data;
    logic                 arb_valid;
    logic [DataWidth-1:0] arb_data;
    logic [NumInp-1:0]    arb_ready;

    // Round-robin search split in two halves: the lowest valid index at or
    // above the pointer wins; otherwise the lowest valid index below it.
    // Scanning downwards leaves the lowest match in each half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NumInp - 1; i >= 0; i--) begin
            if (rsp_valid_i[i]) begin
                if (PtrWidth'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PtrWidth'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PtrWidth'(i);
                end
            end
        end
        rr_idx = hi_found ? hi_idx : lo_idx;
    end

    // Grant is frozen on the locked index during a stall, else round-robin.
    assign grant_idx = locked_q ? lock_idx_q : rr_idx;

    // Select the granted input's valid and payload with a decoded mux so
    // no variable part-select is needed.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NumInp; i++) begin
            if (PtrWidth'(i) == grant_idx) begin
                sel_valid = rsp_valid_i[i];
                sel_data  = rsp_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // Output valid never looks at rsp_ready_i; data is zeroed when idle.
    assign arb_valid = locked_q ? sel_valid : (|rsp_valid_i);
    assign arb_data  = arb_valid ? sel_data : '0;

    generate
        for (gi = 0; gi < NumInp; gi++) begin : g_rdy
            assign arb_ready[gi] = (PtrWidth'(gi) == grant_idx) & rsp_ready_i & arb_valid;
        end
    endgenerate

    // Next-state: advance the pointer past the winner on a handshake, lock
    // on a stall, and drop a lock whose source withdrew its valid.
    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (arb_valid && rsp_ready_i) begin
            locked_d = 1'b0;
            ptr_d    = (grant_idx == PtrWidth'(NumInp - 1)) ? '0 : grant_idx + PtrWidth'(1);
        end else if (arb_valid) begin
            locked_d   = 1'b1;
            lock_idx_d = grant_idx;
        end else if (locked_q) begin
            locked_d = 1'b0;
        end
    end

    // Arbiter state registers; reset clears the lock immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A single-input arbiter degenerates to a straight wire.
    generate
        if (NumInp == 1) begin : g_pass
            assign rsp_data_o  = rsp_data_i[DataWidth-1:0];
            assign rsp_valid_o = rsp_valid_i[0];
            assign rsp_ready_o = rsp_ready_i;
        end else begin : g_arb
            assign rsp_data_o  = arb_data;
            assign rsp_valid_o = arb_valid;
            assign rsp_ready_o = arb_ready;
        end
    endgenerate

endmodule

// File: tb/tb_csr_stream_arb_demux.sv
// Testbench for csr_stream_arb_demux: three instances (2/2, 3/3, 1/1),
// directed scenarios followed by randomized traffic against a model.
module tb_csr_stream_arb_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: NumOut=2, NumInp=2, 32-bit ----------------
    logic        a_req_valid_i, a_req_ready_o;
    logic [0:0]  a_req_sel_i;
    logic [1:0]  a_req_valid_o, a_req_ready_i;
    logic [63:0] a_rsp_data_i;
    logic [1:0]  a_rsp_valid_i, a_rsp_ready_o;
    logic [31:0] a_rsp_data_o;
    logic        a_rsp_valid_o, a_rsp_ready_i;

    csr_stream_arb_demux #(.NumOut(2), .NumInp(2), .DataWidth(32)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid_i), .req_ready_o(a_req_ready_o), .req_sel_i(a_req_sel_i),
        .req_valid_o(a_req_valid_o), .req_ready_i(a_req_ready_i),
        .rsp_data_i(a_rsp_data_i), .rsp_valid_i(a_rsp_valid_i), .rsp_ready_o(a_rsp_ready_o),
        .rsp_data_o(a_rsp_data_o), .rsp_valid_o(a_rsp_valid_o), .rsp_ready_i(a_rsp_ready_i)
    );

    // ---------------- instance B: NumOut=3, NumInp=3, 16-bit ----------------
    logic        b_req_valid_i, b_req_ready_o;
    logic [1:0]  b_req_sel_i;
    logic [2:0]  b_req_valid_o, b_req_ready_i;
    logic [47:0] b_rsp_data_i;
    logic [2:0]  b_rsp_valid_i, b_rsp_ready_o;
    logic [15:0] b_rsp_data_o;
    logic        b_rsp_valid_o, b_rsp_ready_i;

    csr_stream_arb_demux #(.NumOut(3), .NumInp(3), .DataWidth(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid_i), .req_ready_o(b_req_ready_o), .req_sel_i(b_req_sel_i),
        .req_valid_o(b_req_valid_o), .req_ready_i(b_req_ready_i),
        .rsp_data_i(b_rsp_data_i), .rsp_valid_i(b_rsp_valid_i), .rsp_ready_o(b_rsp_ready_o),
        .rsp_data_o(b_rsp_data_o), .rsp_valid_o(b_rsp_valid_o), .rsp_ready_i(b_rsp_ready_i)
    );

    // ---------------- instance C: NumOut=1, NumInp=1, 32-bit ----------------
    logic        c_req_valid_i, c_req_ready_o;
    logic [0:0]  c_req_sel_i;
    logic [0:0]  c_req_valid_o, c_req_ready_i;
    logic [31:0] c_rsp_data_i;
    logic [0:0]  c_rsp_valid_i, c_rsp_ready_o;
    logic [31:0] c_rsp_data_o;
    logic        c_rsp_valid_o, c_rsp_ready_i;

    csr_stream_arb_demux #(.NumOut(1), .NumInp(1), .DataWidth(32)) dut_c (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(c_req_valid_i), .req_ready_o(c_req_ready_o), .req_sel_i(c_req_sel_i),
        .req_valid_o(c_req_valid_o), .req_ready_i(c_req_ready_i),
        .rsp_data_i(c_rsp_data_i), .rsp_valid_i(c_rsp_valid_i), .rsp_ready_o(c_rsp_ready_o),
        .rsp_data_o(c_rsp_data_o), .rsp_valid_o(c_rsp_valid_o), .rsp_ready_i(c_rsp_ready_i)
    );

    // ---------------- reference model (instances A=0, B=1) ----------------
    int m_ptr[2];
    int m_lock[2];
    bit m_locked[2];

    // Grant per the arbitration rules: locked index, else first valid
    // scanning cyclically from the pointer.
    function automatic void mgrant(input int k, input int n, input logic [2:0] v,
                                   output int g, output bit vo);
        if (m_locked[k]) begin
            g  = m_lock[k];
            vo = v[g];
        end else begin
            g  = 0;
            vo = 1'b0;
            for (int off = 0; off < n; off++) begin
                if (!vo && v[(m_ptr[k] + off) % n]) begin
                    g  = (m_ptr[k] + off) % n;
                    vo = 1'b1;
                end
            end
        end
    endfunction

    function automatic void mreset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k]    = 0;
            m_locked[k] = 1'b0;
            m_lock[k]   = 0;
        end
    endfunction

    function automatic void mupdate(input int k, input int n, input logic [2:0] v, input bit rdy);
        int g;
        bit vo;
        mgrant(k, n, v, g, vo);
        if (vo && rdy) begin
            m_ptr[k]    = (g + 1) % n;
            m_locked[k] = 1'b0;
        end else if (vo) begin
            m_locked[k] = 1'b1;
            m_lock[k]   = g;
        end else begin
            m_locked[k] = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_model(input string tag);
        int g;
        bit vo;
        logic [31:0] ed;
        logic [1:0]  er;
        mgrant(0, 2, {1'b0, a_rsp_valid_i}, g, vo);
        ed = vo ? a_rsp_data_i[g*32 +: 32] : 32'h0;
        er = (vo && a_rsp_ready_i) ? 2'(1 << g) : 2'b00;
        chk({tag, ".a.valid"}, a_rsp_valid_o, vo);
        chk({tag, ".a.data"},  a_rsp_data_o,  ed);
        chk({tag, ".a.ready"}, a_rsp_ready_o, er);
        if (vo && a_rsp_ready_i)
            $display("rsp handshake A idx=%0d data=%08h", g, ed);
    endtask

    task automatic check_b_model(input string tag);
        int g;
        bit vo;
        logic [15:0] ed;
        logic [2:0]  er;
        mgrant(1, 3, b_rsp_valid_i, g, vo);
        ed = vo ? b_rsp_data_i[g*16 +: 16] : 16'h0;
        er = (vo && b_rsp_ready_i) ? 3'(1 << g) : 3'b000;
        chk({tag, ".b.valid"}, b_rsp_valid_o, vo);
        chk({tag, ".b.data"},  b_rsp_data_o,  ed);
        chk({tag, ".b.ready"}, b_rsp_ready_o, er);
    endtask

    task automatic check_demux(input string tag);
        logic [1:0] ea;
        logic [2:0] eb;
        ea = (a_req_valid_i && a_req_sel_i < 2) ? 2'(1 << a_req_sel_i) : 2'b00;
        eb = (b_req_valid_i && b_req_sel_i < 3) ? 3'(1 << b_req_sel_i) : 3'b000;
        chk({tag, ".a.req_valid_o"}, a_req_valid_o, ea);
        chk({tag, ".a.req_ready_o"}, a_req_ready_o, (a_req_sel_i < 2) ? a_req_ready_i[a_req_sel_i] : 1'b0);
        chk({tag, ".b.req_valid_o"}, b_req_valid_o, eb);
        chk({tag, ".b.req_ready_o"}, b_req_ready_o, (b_req_sel_i < 3) ? b_req_ready_i[b_req_sel_i] : 1'b0);
    endtask

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic tick();
        if (!rst_n) begin
            mreset();
        end else begin
            mupdate(0, 2, {1'b0, a_rsp_valid_i}, a_rsp_ready_i);
            mupdate(1, 3, b_rsp_valid_i, b_rsp_ready_i);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset with all inputs low: every output is zero ----
        rst_n = 1'b0;
        a_req_valid_i = 0; a_req_sel_i = 0; a_req_ready_i = 0;
        a_rsp_data_i = 0; a_rsp_valid_i = 0; a_rsp_ready_i = 0;
        b_req_valid_i = 0; b_req_sel_i = 0; b_req_ready_i = 0;
        b_rsp_data_i = 0; b_rsp_valid_i = 0; b_rsp_ready_i = 0;
        c_req_valid_i = 0; c_req_sel_i = 0; c_req_ready_i = 0;
        c_rsp_data_i = 0; c_rsp_valid_i = 0; c_rsp_ready_i = 0;
        mreset();
        #2;
        chk("rst.req_valid_o", a_req_valid_o, 0);
        chk("rst.req_ready_o", a_req_ready_o, 0);
        chk("rst.rsp_valid_o", a_rsp_valid_o, 0);
        chk("rst.rsp_data_o",  a_rsp_data_o,  0);
        chk("rst.rsp_ready_o", a_rsp_ready_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // ---- demux routing on NumOut=2 ----
        a_req_sel_i = 1; a_req_valid_i = 1; a_req_ready_i = 2'b10;
        #1;
        chk("dmx2.sel1.valid", a_req_valid_o, 2'b10);
        chk("dmx2.sel1.ready", a_req_ready_o, 1'b1);
        a_req_ready_i = 2'b01;
        #1;
        chk("dmx2.sel1.notready", a_req_ready_o, 1'b0);
        a_req_sel_i = 0;
        #1;
        chk("dmx2.sel0.valid", a_req_valid_o, 2'b01);
        chk("dmx2.sel0.ready", a_req_ready_o, 1'b1);

        // ---- demux out-of-range on NumOut=3 ----
        b_req_sel_i = 3; b_req_valid_i = 1; b_req_ready_i = 3'b111;
        #1;
        chk("dmx3.oor.valid", b_req_valid_o, 3'b000);
        chk("dmx3.oor.ready", b_req_ready_o, 1'b0);
        b_req_sel_i = 2;
        #1;
        chk("dmx3.sel2.valid", b_req_valid_o, 3'b100);
        chk("dmx3.sel2.ready", b_req_ready_o, 1'b1);

        // ---- round-robin fairness, both inputs valid, always ready ----
        a_rsp_data_i = {32'hB1, 32'hA0}; a_rsp_valid_i = 2'b11; a_rsp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr.data",  a_rsp_data_o,  (i % 2 == 0) ? 32'hA0 : 32'hB1);
            chk("rr.ready", a_rsp_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr.valid", a_rsp_valid_o, 1'b1);
            tick();
        end

        // ---- lock-in: input 1 stalls, input 0 appears mid-stall ----
        a_rsp_data_i = {32'h55, 32'hA0}; a_rsp_valid_i = 2'b10; a_rsp_ready_i = 1'b0;
        #1;
        chk("lock.c0.data",  a_rsp_data_o,  32'h55);
        chk("lock.c0.ready", a_rsp_ready_o, 2'b00);
        tick();
        a_rsp_valid_i = 2'b11;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("lock.hold.data",  a_rsp_data_o,  32'h55);
            chk("lock.hold.valid", a_rsp_valid_o, 1'b1);
            tick();
        end
        a_rsp_ready_i = 1'b1;
        #1;
        chk("lock.hs.data",  a_rsp_data_o,  32'h55);
        chk("lock.hs.ready", a_rsp_ready_o, 2'b10);
        tick();
        #1;
        chk("lock.next.data",  a_rsp_data_o,  32'hA0);
        chk("lock.next.ready", a_rsp_ready_o, 2'b01);
        tick();

        // ---- idle: no valid inputs ----
        a_rsp_valid_i = 2'b00;
        #1;
        chk("idle.valid", a_rsp_valid_o, 1'b0);
        chk("idle.data",  a_rsp_data_o,  32'h0);
        chk("idle.ready", a_rsp_ready_o, 2'b00);
        tick();

        // ---- locked source withdraws its valid ----
        a_rsp_valid_i = 2'b10; a_rsp_ready_i = 1'b0;
        tick();
        a_rsp_valid_i = 2'b01; a_rsp_ready_i = 1'b1;
        #1;
        chk("drop.valid", a_rsp_valid_o, 1'b0);
        chk("drop.ready", a_rsp_ready_o, 2'b00);
        tick();
        a_rsp_valid_i = 2'b11; a_rsp_ready_i = 1'b0;
        #1;
        chk("drop.resume.data", a_rsp_data_o, 32'h55);
        tick();

        // ---- reset while locked on input 1 with input 0 valid ----
        rst_n = 1'b0;
        mreset();
        #1;
        chk("rstlock.data",  a_rsp_data_o,  32'hA0);
        chk("rstlock.valid", a_rsp_valid_o, 1'b1);
        a_rsp_ready_i = 1'b1;
        #1;
        chk("rstlock.ready", a_rsp_ready_o, 2'b01);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstrel.data0", a_rsp_data_o, 32'hA0);
        tick();
        chk("rstrel.data1", a_rsp_data_o, 32'h55);
        tick();

        // ---- single input pass-through ----
        c_rsp_valid_i = 1'b1; c_rsp_data_i = 32'h1234;
        c_req_sel_i = 0; c_req_valid_i = 1'b1; c_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_rsp_ready_i = (i % 2 == 0);
            #1;
            chk("one.data",  c_rsp_data_o,  32'h1234);
            chk("one.valid", c_rsp_valid_o, 1'b1);
            chk("one.ready", c_rsp_ready_o, c_rsp_ready_i);
            tick();
        end
        chk("one.dmx.valid", c_req_valid_o, 1'b1);
        chk("one.dmx.ready", c_req_ready_o, 1'b1);
        c_req_sel_i = 1;
        #1;
        chk("one.dmx.oor.valid", c_req_valid_o, 1'b0);
        chk("one.dmx.oor.ready", c_req_ready_o, 1'b0);

        // ---- randomized traffic on A and B against the model ----
        for (int i = 0; i < 300; i++) begin
            a_rsp_valid_i = 2'($urandom_range(0, 3));
            a_rsp_data_i  = {$urandom, $urandom};
            a_rsp_ready_i = ($urandom_range(0, 3) != 0);
            b_rsp_valid_i = 3'($urandom_range(0, 7));
            b_rsp_data_i  = {16'($urandom), 16'($urandom), 16'($urandom)};
            b_rsp_ready_i = ($urandom_range(0, 2) != 0);
            a_req_valid_i = 1'($urandom);
            a_req_sel_i   = 1'($urandom);
            a_req_ready_i = 2'($urandom);
            b_req_valid_i = 1'($urandom);
            b_req_sel_i   = 2'($urandom_range(0, 3));
            b_req_ready_i = 3'($urandom);
            #1;
            check_a_model("rnd");
            check_b_model("rnd");
            check_demux("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
